// File: rtl/echo_ctrl_pkg.sv
// Shared types and helpers for the Echo_control ping scheduler.
package echo_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_POST      = 3'd4,
    S_GAP       = 3'd5
  } state_e;

  localparam int RESULT_W = 16;

  // First set mask bit strictly after 'last', wrapping over n channels (n <= 8).
  // Returns 'last' when the mask is empty.
  function automatic int rr_next(input logic [7:0] mask, input int last, input int n);
    int idx;
    int pick;
    pick = last;
    for (int k = 8; k >= 1; k--) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && mask[idx[2:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/echo_tick_prescaler.sv
// Microsecond tick generator. Reload restarts the count so the first tick
// lands exactly DIV cycles after the reload request.
module echo_tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running divider, restarted on reload or after each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (reload || tick)  cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/echo_sensor_scheduler.sv
// Round-robin ultrasonic ping scheduler: one trigger/measurement engine
// shared by NUM_SENSORS channels, one result posted per ping.
module echo_sensor_scheduler
  import echo_ctrl_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter int CLK_PER_US  = 1,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 30000,
  parameter int GAP_US      = 10000
) (
  input  logic                           CLK,
  input  logic                           RESETN,
  input  logic                           ENABLE,
  input  logic [NUM_SENSORS-1:0]         SENSOR_MASK,
  input  logic [NUM_SENSORS-1:0]         ECHO,
  output logic [NUM_SENSORS-1:0]         TRIG,
  output logic                           BUSY,
  output logic                           RESULT_VALID,
  output logic [$clog2(NUM_SENSORS)-1:0] RESULT_ID,
  output logic [RESULT_W-1:0]            RESULT_US,
  output logic                           RESULT_TIMEOUT
);

  localparam int IDW = $clog2(NUM_SENSORS);
  localparam logic [RESULT_W-1:0] TRIG_LAST = RESULT_W'(TRIG_US - 1);
  localparam logic [RESULT_W-1:0] TMO_LAST  = RESULT_W'(TIMEOUT_US - 1);
  localparam logic [RESULT_W-1:0] TMO_VAL   = RESULT_W'(TIMEOUT_US);
  localparam logic [RESULT_W-1:0] GAP_LAST  = RESULT_W'(GAP_US - 1);

  state_e                   state_q, state_d;
  logic [IDW-1:0]           cur_q, cur_d, last_q, rr_pick;
  logic [RESULT_W-1:0]      cnt_q, width_q, us_d;
  logic [NUM_SENSORS-1:0]   echo_sync_p0, echo_sync_p1, echo_sync_p2;
  logic [NUM_SENSORS-1:0]   trig_d;
  logic                     echo_cur, echo_rise, tick, reload, tmo_hit;
  logic                     busy_d, post_d;

  echo_tick_prescaler #(.DIV(CLK_PER_US)) u_prescaler (
    .clk    (CLK),
    .rst_n  (RESETN),
    .reload (reload),
    .tick   (tick)
  );

  // Two-flop synchronizer plus one history flop for rising-edge detection
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      echo_sync_p0 <= '0;
      echo_sync_p1 <= '0;
      echo_sync_p2 <= '0;
    end else begin
      echo_sync_p0 <= ECHO;
      echo_sync_p1 <= echo_sync_p0;
      echo_sync_p2 <= echo_sync_p1;
    end
  end

  assign echo_cur  = echo_sync_p1[cur_q];
  assign echo_rise = echo_cur & ~echo_sync_p2[cur_q];
  assign tmo_hit   = tick && (cnt_q == TMO_LAST) &&
                     (state_q == S_WAIT_RISE || state_q == S_MEASURE);
  assign reload    = (state_d != state_q);
  assign rr_pick   = IDW'(rr_next(8'(SENSOR_MASK), int'(last_q), NUM_SENSORS));

  // State register, current channel and last-served pointer
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= IDW'(NUM_SENSORS - 1);
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (state_q == S_POST) last_q <= cur_q;
    end
  end

  // Next-state logic; timeout wins over an echo edge on the same tick
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      S_IDLE: begin
        if (ENABLE && (|SENSOR_MASK)) begin
          state_d = S_TRIG;
          cur_d   = rr_pick;
        end
      end
      S_TRIG:      if (tick && cnt_q == TRIG_LAST) state_d = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (tmo_hit)        state_d = S_POST;
        else if (echo_rise) state_d = S_MEASURE;
      end
      S_MEASURE:   if (tmo_hit || !echo_cur) state_d = S_POST;
      S_POST:      state_d = S_GAP;
      S_GAP:       if (tick && cnt_q == GAP_LAST) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Tick counter for trigger width, timeout window (spans WAIT_RISE and MEASURE) and gap
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)                              cnt_q <= '0;
    else if (reload && state_d != S_MEASURE)  cnt_q <= '0;
    else if (tick && state_q != S_IDLE)       cnt_q <= cnt_q + RESULT_W'(1);
  end

  // Echo width in ticks; the tick that sees the rising edge counts as the first
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)
      width_q <= '0;
    else if (reload && state_d == S_WAIT_RISE)
      width_q <= '0;
    else if (tick && ((state_q == S_WAIT_RISE && echo_rise) ||
                      (state_q == S_MEASURE && echo_cur)))
      width_q <= width_q + RESULT_W'(1);
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    trig_d = '0;
    if (state_d == S_TRIG) trig_d[cur_d] = 1'b1;
    busy_d = (state_d != S_IDLE);
    post_d = (state_d == S_POST);
    us_d   = tmo_hit ? TMO_VAL : width_q;
  end

  // Registered outputs; result fields hold until the next post
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      TRIG           <= '0;
      BUSY           <= 1'b0;
      RESULT_VALID   <= 1'b0;
      RESULT_ID      <= '0;
      RESULT_US      <= '0;
      RESULT_TIMEOUT <= 1'b0;
    end else begin
      TRIG         <= trig_d;
      BUSY         <= busy_d;
      RESULT_VALID <= post_d;
      if (post_d) begin
        RESULT_ID      <= cur_q;
        RESULT_US      <= us_d;
        RESULT_TIMEOUT <= tmo_hit;
      end
    end
  end

endmodule
